// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the producers/FIFO side and the round-robin arbiter.
// Latency: none (signal grouping only).
// Backpressure: fifo_full travels toward the arbiter, req_ready back to the producers.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_W       = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          grant_valid;
    logic [ID_W-1:0]               grant_id;
    logic [7:0]                    beat_cnt;

    // Producer/FIFO side: drives requests and the full flag.
    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_data, grant_valid, grant_id, beat_cnt
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_data, grant_valid, grant_id, beat_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_memory write port among NUM_REQ producers, grant held per burst.
// Latency: one idle bubble cycle per new grant; data passes combinationally while granted.
// Backpressure: fifo_full gates only the granted requester's ready; a stalled beat holds beat_cnt and release.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4,
    parameter int ID_W       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [7:0]      beat_q,  beat_d;
    logic [ID_W-1:0] last_ptr_q, last_ptr_d;

    logic [ID_W-1:0] sel_id;
    logic            sel_found;
    logic [ID_W-1:0] probe;
    logic            wr_en;
    logic            release_now;

    // Round-robin pick: first valid requester after the last one served.
    always_comb begin
        sel_id    = '0;
        sel_found = 1'b0;
        probe     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            probe = ID_W'((int'(last_ptr_q) + k) % NUM_REQ);
            if (!sel_found && bus.req_valid[probe]) begin
                sel_found = 1'b1;
                sel_id    = probe;
            end
        end
    end

    // Datapath toward the FIFO; everything is quiet outside GRANT.
    always_comb begin
        bus.req_ready   = '0;
        bus.fifo_data   = '0;
        wr_en           = 1'b0;
        if (state_q == GRANT) begin
            if (!bus.fifo_full) begin
                bus.req_ready = NUM_REQ'(1) << grant_q;
            end
            wr_en = bus.req_valid[grant_q] & ~bus.fifo_full;
            if (wr_en) begin
                bus.fifo_data = bus.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        bus.fifo_wr_en  = wr_en;
        bus.grant_valid = (state_q == GRANT);
        bus.grant_id    = grant_q;
        bus.beat_cnt    = beat_q;
    end

    // Release only on a beat that actually transfers: marked last or burst cap reached.
    assign release_now = wr_en & (bus.req_last[grant_q] | (beat_q == 8'(MAX_BURST - 1)));

    // Next-state logic for the grant FSM, beat counter and priority pointer.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beat_d     = beat_q;
        last_ptr_d = last_ptr_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = GRANT;
                    grant_d = sel_id;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d    = IDLE;
                    last_ptr_d = grant_q;
                    grant_d    = '0;
                    beat_d     = '0;
                end else if (wr_en) begin
                    beat_d = beat_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset leaves requester 0 as the top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            beat_q     <= '0;
            last_ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_q     <= beat_d;
            last_ptr_q <= last_ptr_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for the round-robin FIFO write arbiter.
// Latency: checks one bubble per grant and combinational beat transfer.
// Backpressure: exercises fifo_full stalls, including on the last beat.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 16;
    localparam int MAX_BURST  = 4;
    localparam int ID_W       = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ID_W(ID_W)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST), .ID_W(ID_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed snapshot: grant_valid, grant_id, beat_cnt, req_ready, fifo_wr_en, fifo_data.
    logic [31:0] obs;
    assign obs = {bus.grant_valid, bus.grant_id, bus.beat_cnt, bus.req_ready, bus.fifo_wr_en, bus.fifo_data};

    function automatic logic [31:0] mk(input logic gv, input logic [1:0] gid, input logic [7:0] bc,
                                       input logic [3:0] rdy, input logic we, input logic [15:0] dat);
        return {gv, gid, bc, rdy, we, dat};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [15:0] val);
        bus.req_data[idx*DATA_WIDTH +: DATA_WIDTH] = val;
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        bus.req_data  = 64'h4444_3333_2222_1111;
        #3;
        total++;
        if (obs !== 32'h0) begin bad++; $display("FAIL reset_initial: got %h want %h", obs, 32'h0); end
        step();
        #1;
        total++;
        if (obs !== 32'h0) begin bad++; $display("FAIL reset_held: got %h want %h", obs, 32'h0); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_burst();
        logic [31:0] exp;
        apply_reset();
        bus.req_valid = 4'b0001;
        set_data(0, 16'hABCD);
        #1;
        total++;
        if (obs !== 32'h0) begin bad++; $display("FAIL single_idle: got %h want %h", obs, 32'h0); end
        step();
        #1; exp = mk(1'b1, 2'd0, 8'd0, 4'b0001, 1'b1, 16'hABCD);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL single_beat0: got %h want %h", obs, exp); end
        step();
        set_data(0, 16'h1234);
        #1; exp = mk(1'b1, 2'd0, 8'd1, 4'b0001, 1'b1, 16'h1234);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL single_beat1: got %h want %h", obs, exp); end
        step();
        set_data(0, 16'hAFE9);
        bus.req_last = 4'b0001;
        #1; exp = mk(1'b1, 2'd0, 8'd2, 4'b0001, 1'b1, 16'hAFE9);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL single_beat2: got %h want %h", obs, exp); end
        step();
        // Requesters 0 and 1 both valid: last_ptr=0 must favour 1.
        bus.req_valid = 4'b0011;
        bus.req_last  = 4'b0011;
        set_data(1, 16'h5A5A);
        #1;
        total++;
        if (obs !== 32'h0) begin bad++; $display("FAIL single_release: got %h want %h", obs, 32'h0); end
        step();
        bus.req_valid = 4'b0000;
        #1; exp = mk(1'b1, 2'd1, 8'd0, 4'b0010, 1'b0, 16'h0000);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL single_ptr_next: got %h want %h", obs, exp); end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [31:0] exp;
        logic [1:0]  g;
        apply_reset();
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 16'(16'h1000 + i));
        for (int n = 0; n < 6; n++) begin
            g = 2'(n % NUM_REQ);
            #1;
            total++;
            if (obs !== 32'h0) begin bad++; $display("FAIL rr_bubble%0d: got %h want %h", n, obs, 32'h0); end
            step();
            #1; exp = mk(1'b1, g, 8'd0, 4'(4'b0001 << g), 1'b1, 16'(16'h1000 + g));
            total++;
            if (obs !== exp) begin bad++; $display("FAIL rr_grant%0d: got %h want %h", n, obs, exp); end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_forced_release();
        logic [31:0] exp;
        apply_reset();
        bus.req_valid = 4'b0110;
        bus.req_last  = 4'b0100;
        set_data(1, 16'h1100);
        set_data(2, 16'h2200);
        step();
        for (int k = 0; k < MAX_BURST; k++) begin
            #1; exp = mk(1'b1, 2'd1, 8'(k), 4'b0010, 1'b1, 16'(16'h1100 + k));
            total++;
            if (obs !== exp) begin bad++; $display("FAIL forced_beat%0d: got %h want %h", k, obs, exp); end
            step();
            set_data(1, 16'(16'h1100 + k + 1));
        end
        #1;
        total++;
        if (obs !== 32'h0) begin bad++; $display("FAIL forced_release: got %h want %h", obs, 32'h0); end
        step();
        #1; exp = mk(1'b1, 2'd2, 8'd0, 4'b0100, 1'b1, 16'h2200);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL forced_next_grant: got %h want %h", obs, exp); end
        step();
        bus.req_valid = 4'b0010;
        step();
        #1; exp = mk(1'b1, 2'd1, 8'd0, 4'b0010, 1'b1, 16'h1104);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL forced_regrant: got %h want %h", obs, exp); end
        step();
        set_data(1, 16'h1105);
        bus.req_last = 4'b0010;
        #1; exp = mk(1'b1, 2'd1, 8'd1, 4'b0010, 1'b1, 16'h1105);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL forced_tail: got %h want %h", obs, exp); end
        step();
        clear_inputs();
        #1;
        total++;
        if (obs !== 32'h0) begin bad++; $display("FAIL forced_done: got %h want %h", obs, 32'h0); end
    endtask

    task automatic test_full_stall();
        logic [31:0] exp;
        apply_reset();
        bus.req_valid = 4'b0001;
        set_data(0, 16'hA000);
        step();
        #1; exp = mk(1'b1, 2'd0, 8'd0, 4'b0001, 1'b1, 16'hA000);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stall_beat0: got %h want %h", obs, exp); end
        step();
        set_data(0, 16'hA001);
        bus.fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1; exp = mk(1'b1, 2'd0, 8'd1, 4'b0000, 1'b0, 16'h0000);
            total++;
            if (obs !== exp) begin bad++; $display("FAIL stall_hold%0d: got %h want %h", s, obs, exp); end
            step();
        end
        bus.fifo_full = 1'b0;
        #1; exp = mk(1'b1, 2'd0, 8'd1, 4'b0001, 1'b1, 16'hA001);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stall_resume: got %h want %h", obs, exp); end
        step();
        set_data(0, 16'hA002);
        bus.req_last = 4'b0001;
        #1; exp = mk(1'b1, 2'd0, 8'd2, 4'b0001, 1'b1, 16'hA002);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stall_beat2: got %h want %h", obs, exp); end
        step();
        clear_inputs();
        #1;
        total++;
        if (obs !== 32'h0) begin bad++; $display("FAIL stall_done: got %h want %h", obs, 32'h0); end
    endtask

    task automatic test_full_last();
        logic [31:0] exp;
        apply_reset();
        bus.req_valid = 4'b0001;
        bus.req_last  = 4'b0001;
        bus.fifo_full = 1'b1;
        set_data(0, 16'hB000);
        step();
        for (int s = 0; s < 2; s++) begin
            #1; exp = mk(1'b1, 2'd0, 8'd0, 4'b0000, 1'b0, 16'h0000);
            total++;
            if (obs !== exp) begin bad++; $display("FAIL fulllast_hold%0d: got %h want %h", s, obs, exp); end
            step();
        end
        bus.fifo_full = 1'b0;
        #1; exp = mk(1'b1, 2'd0, 8'd0, 4'b0001, 1'b1, 16'hB000);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL fulllast_xfer: got %h want %h", obs, exp); end
        step();
        bus.req_valid = 4'b0000;
        #1;
        total++;
        if (obs !== 32'h0) begin bad++; $display("FAIL fulllast_release: got %h want %h", obs, 32'h0); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] exp;
        apply_reset();
        bus.req_valid = 4'b1000;
        set_data(3, 16'hC000);
        step();
        step();
        set_data(3, 16'hC001);
        #1; exp = mk(1'b1, 2'd3, 8'd1, 4'b1000, 1'b1, 16'hC001);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL midrst_beat1: got %h want %h", obs, exp); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 32'h0) begin bad++; $display("FAIL midrst_async: got %h want %h", obs, 32'h0); end
        bus.req_valid = 4'b1010;
        bus.req_last  = 4'b1010;
        set_data(1, 16'hD000);
        step();
        rst_n = 1'b1;
        #1;
        total++;
        if (obs !== 32'h0) begin bad++; $display("FAIL midrst_idle: got %h want %h", obs, 32'h0); end
        step();
        #1; exp = mk(1'b1, 2'd1, 8'd0, 4'b0010, 1'b1, 16'hD000);
        total++;
        if (obs !== exp) begin bad++; $display("FAIL midrst_first_grant: got %h want %h", obs, exp); end
        clear_inputs();
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_forced_release();
        test_full_stall();
        test_full_last();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of fifo_memory (16-bit in, 4-bit out width converter) between NUM_REQ producers in the neural_net datapath, for example weight and activation loaders.
- A grant is held for a whole burst: until the requester marks its last beat, or until MAX_BURST beats have been written.
- Backpressure from fifo_memory full is passed to the granted requester only.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 16, write data width; equals fifo_memory DATA_IN_WIDTH
MAX_BURST, 4, maximum beats per grant before forced release (1..255)
ID_W, 2, grant index width; equals clog2(NUM_REQ)

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester data valid
req_last  input  NUM_REQ  per-requester last beat of burst
req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-requester ready; at most one bit high
fifo_full  input  1  full flag from fifo_memory
fifo_wr_en  output  1  write enable to fifo_memory
fifo_data  output  DATA_WIDTH  write data to fifo_memory
grant_valid  output  1  a grant is active (state GRANT)
grant_id  output  ID_W  index of the granted requester; 0 when idle
beat_cnt  output  8  beats written in the current grant

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While rst_n is low: state=IDLE, grant_id=0, beat_cnt=0, last_ptr=NUM_REQ-1.
  - All outputs are 0: req_ready=0, fifo_wr_en=0, fifo_data=0, grant_valid=0.
  - last_ptr=NUM_REQ-1 makes requester 0 highest priority after reset.
- FSM has two states: IDLE and GRANT.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching last_ptr+1, last_ptr+2, ... modulo NUM_REQ.
  - At the clock edge: register that index into grant_id, clear beat_cnt, go to GRANT.
  - If no req_valid bit is set, stay in IDLE.
  - A new grant costs exactly one bubble cycle; fifo_wr_en is 0 during IDLE.
- GRANT, combinational outputs (g = grant_id):
  - req_ready[g] = !fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[g] & !fifo_full.
  - fifo_data = req_data slice g when fifo_wr_en=1, else 0.
- A beat is transferred when fifo_wr_en=1. On each beat, beat_cnt increments at the clock edge.
- Release from GRANT happens on a transferring beat when req_last[g]=1 or when beat_cnt=MAX_BURST-1. On release:
  - last_ptr<=g, state<=IDLE, beat_cnt<=0.
- Non-granted requesters see ready=0 and must hold their data; nothing they drive reaches the FIFO.
- Stalls:
  - If req_valid[g] drops mid-burst, the grant is held; no timeout.
  - If fifo_full=1, no write occurs and beat_cnt holds. The grant is held even if req_last[g]=1.
  - fifo_full rising in the same cycle as a last beat suppresses that beat; release waits until the beat actually transfers.
- Forced release at MAX_BURST rotates priority the same way a req_last release does. The requester must re-arbitrate for its remaining beats.
- Reset asserted mid-burst: immediate return to reset values. The partial burst already written to fifo_memory is not retracted.
- Invariants: never more than one write per cycle; at most one req_ready bit high (one-hot or zero); fifo_wr_en never high while fifo_full=1.

Test Plan:
- Single burst: req_valid[0]=1 with data 16'hABCD, 16'h1234, 16'hAFE9 (req_last on the 3rd beat), fifo_full=0 -> grant_id=0 from cycle 1; fifo_wr_en high for 3 consecutive cycles carrying those words in order; IDLE on cycle 4; last_ptr=0.
- Round robin: all four req_valid held high, every burst is 1 beat (req_last=1) -> grant order 0,1,2,3,0,1; each grant separated by one IDLE cycle; 2 cycles per beat.
- Forced release: MAX_BURST=4, requester 1 streams 6 beats without req_last while requester 2 is also valid -> after 4 beats (beat_cnt 0..3) the grant moves to 2; requester 1 gets its next grant after 2.
- Full stall: fifo_full=1 for 3 cycles during beat 2 of requester 0 -> req_ready[0]=0, fifo_wr_en=0, beat_cnt holds at 1; burst resumes with beat 2 once full clears; no words lost or duplicated.
- Full on last beat: req_last[0]=1 coincides with fifo_full=1 -> no release; grant_valid stays 1 until the beat transfers the cycle after full deasserts.
- Reset mid-burst: rst_n low asynchronously (between clock edges) during beat 2 of requester 3 -> all outputs 0 immediately; after release of reset with requesters 1 and 3 both valid, requester 1 is granted first (last_ptr reset to NUM_REQ-1).
